window_row_fetcher: RTL

- Upstream feeder for the 4x4 sliding-window row skewer.
- Scans an int8 feature map stored in a 32-bit-word activation SRAM (4 pixels per word, pixel 0 in bits [31:24]).
- For each 4-row x 1-word window, reads the four row words, presents them as four stable 32-bit rows and pulses a one-cycle start to the skewer.
- Prefetches the next window into a shadow bank while the current window is held.

---
 rtl/window_row_fetcher_if.sv | 13 +
 rtl/window_row_fetcher.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_row_fetcher_if.sv
// Activation SRAM read port between the window row fetcher and the SRAM.
//   master (fetcher): drives mem_rd_en / mem_addr, receives mem_rdata
//   slave  (SRAM)   : returns mem_rdata the cycle after mem_rd_en
interface window_row_fetcher_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/window_row_fetcher.sv
// window_row_fetcher: scans an int8 feature map held as 32-bit words
// (4 pixels per word) and feeds the 4x4 sliding-window row skewer with
// 4-row x 1-word windows. The next window is prefetched into a shadow bank
// while the current one is held stable on the row outputs.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           pulse: begin a full-image scan at base_addr
//   base_addr       word address of image row 0 / word 0, sampled with start
//   stall           blocks issuing a new window while high
//   mem             SRAM read port (window_row_fetcher_if.master)
//   row0..3_out     window rows r..r+3 at word column c
//   win_start       one-cycle pulse when a new window is presented
//   win_row/win_col position (r, c) of the presented window
//   busy, done      scan in progress / one-cycle end-of-scan pulse
//
// Build option: define WINFETCH_ZERO_PAD_EN to keep scanning down to the
// last image row; rows below the image are not read and present as zero.
module window_row_fetcher #(
  parameter int IMG_W_WORDS = 8,
  parameter int IMG_H       = 32,
  parameter int ROW_STEP    = 1,
  parameter int HOLD_CYCLES = 5,
  parameter int ADDR_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                stall,
  window_row_fetcher_if.master mem,
  output logic [31:0]         row0_out,
  output logic [31:0]         row1_out,
  output logic [31:0]         row2_out,
  output logic [31:0]         row3_out,
  output logic                win_start,
  output logic [9:0]          win_row,
  output logic [7:0]          win_col,
  output logic                busy,
  output logic                done
);

`ifdef WINFETCH_ZERO_PAD_EN
  localparam int LAST_R = ((IMG_H - 1) / ROW_STEP) * ROW_STEP;
`else
  localparam int LAST_R = ((IMG_H - 4) / ROW_STEP) * ROW_STEP;
`endif
  localparam int HCW = $clog2(HOLD_CYCLES + 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LAST} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [9:0]        r_q, r_d;
  logic [7:0]        c_q, c_d;
  logic [2:0]        fetch_cnt_q, fetch_cnt_d;   // read slots issued for the window being fetched
  logic              slot_vld_q, slot_vld_d;     // a read slot is on the bus this cycle
  logic [1:0]        slot_k_q, slot_k_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cap_vld_q, cap_vld_d;       // mem_rdata belongs to slot cap_k_q this cycle
  logic [1:0]        cap_k_q, cap_k_d;
  logic              cap_rd_q, cap_rd_d;         // slot was really read (else forced to zero)
  logic [3:0][31:0]  shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [3:0][31:0]  rows_q, rows_d;
  logic              win_start_q, win_start_d;
  logic [9:0]        win_row_q, win_row_d;
  logic [7:0]        win_col_q, win_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] issue_base, issue_addr;
  logic [9:0]        issue_r;
  logic [7:0]        issue_c;
  logic [1:0]        issue_k;
  logic [10:0]       issue_row;
  logic              issue_rd, issue;
  logic [31:0]       cap_word;
  logic              data_ready, emit, last_win;

  // Read address of the next slot. The very first slot is issued in the
  // same cycle start is accepted, so it uses base_addr and (0,0) directly.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    issue_base = base_q;
    issue_r    = r_q;
    issue_c    = c_q;
    issue_k    = fetch_cnt_q[1:0];
    if (state_q == S_IDLE) begin
      issue_base = base_addr;
      issue_r    = '0;
      issue_c    = '0;
      issue_k    = '0;
    end
    issue_row  = {1'b0, issue_r} + {9'b0, issue_k};
    issue_addr = issue_base + ADDR_W'(int'(issue_row) * IMG_W_WORDS) + ADDR_W'(issue_c);
`ifdef WINFETCH_ZERO_PAD_EN
    issue_rd   = int'(issue_row) < IMG_H;
`else
    issue_rd   = 1'b1;
`endif
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    r_d           = r_q;
    c_d           = c_q;
    fetch_cnt_d   = fetch_cnt_q;
    slot_vld_d    = 1'b0;
    slot_k_d      = slot_k_q;
    rd_en_d       = 1'b0;
    addr_d        = addr_q;
    cap_vld_d     = slot_vld_q;
    cap_k_d       = slot_k_q;
    cap_rd_d      = rd_en_q;
    shadow_full_d = shadow_full_q;
    hold_cnt_d    = (hold_cnt_q != '0) ? hold_cnt_q - 1'b1 : hold_cnt_q;
    rows_d        = rows_q;
    win_start_d   = 1'b0;
    win_row_d     = win_row_q;
    win_col_d     = win_col_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    issue         = 1'b0;

    // Capture: shadow_d is also the emit source, so the fourth word can be
    // forwarded straight to the outputs in the cycle it arrives.
    cap_word = cap_rd_q ? mem.mem_rdata : 32'h0;
    for (int k = 0; k < 4; k++)
      shadow_d[k] = (cap_vld_q && cap_k_q == 2'(k)) ? cap_word : shadow_q[k];
    if (cap_vld_q && cap_k_q == 2'd3) shadow_full_d = 1'b1;

    data_ready = shadow_full_q || (cap_vld_q && cap_k_q == 2'd3);
    emit       = (state_q == S_FETCH) && data_ready && (hold_cnt_q == '0) && !stall;
    last_win   = (r_q == 10'(LAST_R)) && (c_q == 8'(IMG_W_WORDS - 1));

    unique case (state_q)
      S_IDLE: begin
        // done_q blocks a start arriving in the done cycle itself.
        if (start && !done_q) begin
          base_d      = base_addr;
          r_d         = '0;
          c_d         = '0;
          busy_d      = 1'b1;
          fetch_cnt_d = 3'd1;
          issue       = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_cnt_q != 3'd4) begin
          issue       = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 3'd1;
        end
        if (emit) begin
          rows_d        = shadow_d;
          win_start_d   = 1'b1;
          win_row_d     = r_q;
          win_col_d     = c_q;
          shadow_full_d = 1'b0;
          hold_cnt_d    = HCW'(HOLD_CYCLES);
          if (last_win) begin
            state_d = S_LAST;
          end else begin
            // Prefetch of the next window starts the cycle after emit.
            fetch_cnt_d = '0;
            if (c_q == 8'(IMG_W_WORDS - 1)) begin
              c_d = '0;
              r_d = r_q + 10'(ROW_STEP);
            end else begin
              c_d = c_q + 8'd1;
            end
          end
        end
      end
      S_LAST: begin
        if (hold_cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      slot_vld_d = 1'b1;
      slot_k_d   = issue_k;
      rd_en_d    = issue_rd;
      addr_d     = issue_addr;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      r_q           <= '0;
      c_q           <= '0;
      fetch_cnt_q   <= '0;
      slot_vld_q    <= 1'b0;
      slot_k_q      <= '0;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      cap_vld_q     <= 1'b0;
      cap_k_q       <= '0;
      cap_rd_q      <= 1'b0;
      shadow_full_q <= 1'b0;
      hold_cnt_q    <= '0;
      rows_q        <= '0;
      win_start_q   <= 1'b0;
      win_row_q     <= '0;
      win_col_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      r_q           <= r_d;
      c_q           <= c_d;
      fetch_cnt_q   <= fetch_cnt_d;
      slot_vld_q    <= slot_vld_d;
      slot_k_q      <= slot_k_d;
      rd_en_q       <= rd_en_d;
      addr_q        <= addr_d;
      cap_vld_q     <= cap_vld_d;
      cap_k_q       <= cap_k_d;
      cap_rd_q      <= cap_rd_d;
      shadow_full_q <= shadow_full_d;
      hold_cnt_q    <= hold_cnt_d;
      rows_q        <= rows_d;
      win_start_q   <= win_start_d;
      win_row_q     <= win_row_d;
      win_col_q     <= win_col_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // NOTE: the shadow bank holds data only; its contents are meaningless
  // until shadow_full / cap_vld say otherwise, so it carries no reset.
  always_ff @(posedge clk) shadow_q <= shadow_d;

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;
  assign row0_out      = rows_q[0];
  assign row1_out      = rows_q[1];
  assign row2_out      = rows_q[2];
  assign row3_out      = rows_q[3];
  assign win_start     = win_start_q;
  assign win_row       = win_row_q;
  assign win_col       = win_col_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
